// File: rtl/regfile_pkg.sv
// Shared types and helpers for the parametrised register file with busy scoreboard.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int MAX_DEPTH = 256;
  localparam int MAX_AW    = $clog2(MAX_DEPTH);

  // Wide enough for any supported depth; narrower addresses are zero-extended into it.
  typedef logic [MAX_AW-1:0] reg_addr_t;

  function automatic logic [MAX_DEPTH-1:0] onehot(input reg_addr_t addr, input int depth);
    logic [MAX_DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if ((i < depth) && (addr == reg_addr_t'(i))) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Writeback, read-port and issue/scoreboard signals between ID-stage issue logic and the register file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    rw;
  logic [WIDTH-1:0] wd;
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [WIDTH-1:0] rda;
  logic [WIDTH-1:0] rdb;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             issue_rd_en;
  logic             stall;
  logic [DEPTH-1:0] busy;

  modport master (
    output we, rw, wd, ra, rb, issue_valid, issue_rd, issue_rd_en,
    input  rda, rdb, stall, busy
  );

  modport slave (
    input  we, rw, wd, ra, rb, issue_valid, issue_rd, issue_rd_en,
    output rda, rdb, stall, busy
  );

endinterface

// File: rtl/regfile_busy_sb.sv
// Per-register busy scoreboard: tracks in-flight multi-cycle producers and raises stall on RAW/WAW hazards.
module regfile_busy_sb
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    rw,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_rd_en,
  output logic             stall,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0]     busy_q;
  logic [DEPTH-1:0]     busy_d;
  logic [DEPTH-1:0]     clr_mask;
  logic [DEPTH-1:0]     set_mask;
  logic [DEPTH-1:0]     eff_busy;
  logic [MAX_DEPTH-1:0] wb_oh;
  logic [MAX_DEPTH-1:0] rd_oh;
  logic                 hazard;
  logic                 set_ok;
  logic                 unused_oh;

  assign wb_oh     = onehot(reg_addr_t'(rw), DEPTH);
  assign rd_oh     = onehot(reg_addr_t'(issue_rd), DEPTH);
  assign unused_oh = ^{wb_oh, rd_oh};

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (we) clr_mask = wb_oh[DEPTH-1:0];
    // A register being written back this cycle is free: the bypass supplies its value.
    eff_busy = busy_q & ~clr_mask;
    hazard   = issue_valid & (eff_busy[ra] | eff_busy[rb] | (issue_rd_en & eff_busy[issue_rd]));
    set_ok   = issue_valid & ~hazard & issue_rd_en &
               ~((ZERO_REG != 0) && (issue_rd == '0));
    if (set_ok) set_mask = rd_oh[DEPTH-1:0];
    // Set is applied after clear so a new producer wins over the completing writeback.
    busy_d = (busy_q & ~clr_mask) | set_mask;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign stall = hazard;
  assign busy  = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised ID-stage register file with write-first bypass, optional hardwired zero register and busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 1
) (
  input  logic     clk,
  input  logic     reset,
  regfile_if.slave rf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok;

  // Writes to the hardwired zero register are dropped, so they neither update nor bypass.
  assign wr_ok = rf.we & ~((ZERO_REG != 0) && (rf.rw == AW'(0)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[rf.rw] <= rf.wd;
    end
  end

  always_comb begin
    rf.rda = mem[rf.ra];
    if (wr_ok && (rf.rw == rf.ra)) rf.rda = rf.wd;
    if ((ZERO_REG != 0) && (rf.ra == AW'(0))) rf.rda = '0;
    if (reset) rf.rda = '0;
  end

  always_comb begin
    rf.rdb = mem[rf.rb];
    if (wr_ok && (rf.rw == rf.rb)) rf.rdb = rf.wd;
    if ((ZERO_REG != 0) && (rf.rb == AW'(0))) rf.rdb = '0;
    if (reset) rf.rdb = '0;
  end

  regfile_busy_sb #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_busy_sb (
    .clk         (clk),
    .reset       (reset),
    .we          (rf.we),
    .rw          (rf.rw),
    .ra          (rf.ra),
    .rb          (rf.rb),
    .issue_valid (rf.issue_valid),
    .issue_rd    (rf.issue_rd),
    .issue_rd_en (rf.issue_rd_en),
    .stall       (rf.stall),
    .busy        (rf.busy)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default config plus a 64x32 no-zero-register config, checked every cycle against a behavioural model.
module tb_regfile_scoreboard;

  logic clk;
  logic reset;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_if #(.WIDTH(32), .DEPTH(16)) if0 ();
  regfile_if #(.WIDTH(64), .DEPTH(32)) if1 ();

  regfile_scoreboard #(.WIDTH(32), .DEPTH(16), .ZERO_REG(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .rf    (if0)
  );

  regfile_scoreboard #(.WIDTH(64), .DEPTH(32), .ZERO_REG(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .rf    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: architectural register contents and pending-write set per instance.
  logic [63:0] m_reg  [2][32];
  logic [31:0] m_busy [2];
  int          cfg_zr [2] = '{1, 0};

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_read(int k, logic we, int rw, logic [63:0] wd, int a);
    if (cfg_zr[k] != 0 && a == 0) return 64'h0;
    if (we && rw == a) return wd;
    return m_reg[k][a];
  endfunction

  task automatic model_step(int k, logic rst, logic we, int rw, logic [63:0] wd, int ra, int rb,
                            logic iv, int ird, logic iren,
                            logic [63:0] a_rda, logic [63:0] a_rdb, logic a_stall, logic [31:0] a_busy);
    logic        pend_a, pend_b, pend_d, st;
    string       p;
    p = $sformatf("i%0d.", k);
    if (rst) begin
      check({p, "rst_rda"},   a_rda, 64'h0);
      check({p, "rst_rdb"},   a_rdb, 64'h0);
      check({p, "rst_stall"}, 64'(a_stall), 64'h0);
      check({p, "rst_busy"},  64'(a_busy), 64'h0);
      for (int i = 0; i < 32; i++) m_reg[k][i] = 64'h0;
      m_busy[k] = 32'h0;
      return;
    end
    // A register is a hazard only if pending and not being written back right now.
    pend_a = m_busy[k][ra]  && !(we && rw == ra);
    pend_b = m_busy[k][rb]  && !(we && rw == rb);
    pend_d = m_busy[k][ird] && !(we && rw == ird);
    st = iv && (pend_a || pend_b || (iren && pend_d));
    check({p, "rda"},   a_rda, exp_read(k, we, rw, wd, ra));
    check({p, "rdb"},   a_rdb, exp_read(k, we, rw, wd, rb));
    check({p, "stall"}, 64'(a_stall), 64'(st));
    check({p, "busy"},  64'(a_busy), 64'(m_busy[k]));
    if (we && !(cfg_zr[k] != 0 && rw == 0)) m_reg[k][rw] = wd;
    if (we) m_busy[k][rw] = 1'b0;
    if (iv && !st && iren && !(cfg_zr[k] != 0 && ird == 0)) m_busy[k][ird] = 1'b1;
  endtask

  always @(negedge clk) begin
    model_step(0, reset, if0.we, int'(if0.rw), 64'(if0.wd), int'(if0.ra), int'(if0.rb),
               if0.issue_valid, int'(if0.issue_rd), if0.issue_rd_en,
               64'(if0.rda), 64'(if0.rdb), if0.stall, 32'(if0.busy));
    model_step(1, reset, if1.we, int'(if1.rw), if1.wd, int'(if1.ra), int'(if1.rb),
               if1.issue_valid, int'(if1.issue_rd), if1.issue_rd_en,
               if1.rda, if1.rdb, if1.stall, if1.busy);
  end

  task automatic drv0(logic we, int rw, logic [31:0] wd, int ra, int rb, logic iv, int ird, logic iren);
    if0.we = we; if0.rw = 4'(rw); if0.wd = wd; if0.ra = 4'(ra); if0.rb = 4'(rb);
    if0.issue_valid = iv; if0.issue_rd = 4'(ird); if0.issue_rd_en = iren;
  endtask

  task automatic drv1(logic we, int rw, logic [63:0] wd, int ra, int rb, logic iv, int ird, logic iren);
    if1.we = we; if1.rw = 5'(rw); if1.wd = wd; if1.ra = 5'(ra); if1.rb = 5'(rb);
    if1.issue_valid = iv; if1.issue_rd = 5'(ird); if1.issue_rd_en = iren;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  function automatic int raddr(int depth);
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 3));
    return int'($urandom_range(0, depth - 1));
  endfunction

  initial begin
    reset = 1'b1;
    drv0(0, 0, 0, 0, 1, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("t1_rda",   64'(if0.rda), 64'h0);
    check("t1_rdb",   64'(if0.rdb), 64'h0);
    check("t1_busy",  64'(if0.busy), 64'h0);
    check("t1_stall", 64'(if0.stall), 64'h0);
    edge1(); edge1();
    reset = 1'b0;

    // Write reg 1, then read it back on port B.
    drv0(1, 1, 32'hFFFF0002, 0, 1, 0, 0, 0);
    edge1();
    drv0(0, 0, 0, 0, 1, 0, 0, 0); #1;
    check("t1_rdb_after", 64'(if0.rdb), 64'hFFFF0002);

    // Same-cycle bypass, and zero register ignores writes.
    edge1();
    drv0(1, 3, 32'hFFFF0004, 3, 0, 0, 0, 0); #1;
    check("t2_bypass", 64'(if0.rda), 64'hFFFF0004);
    edge1();
    drv0(1, 0, 32'hFFFF000F, 0, 3, 0, 0, 0); #1;
    check("t2_zero_bypass", 64'(if0.rda), 64'h0);
    check("t2_rdb_r3", 64'(if0.rdb), 64'hFFFF0004);
    edge1();
    drv0(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t2_zero_after", 64'(if0.rda), 64'h0);

    // RAW: issue rd=5, then a reader of 5 stalls until writeback.
    edge1();
    drv0(0, 0, 0, 0, 0, 1, 5, 1); #1;
    check("t3_no_stall", 64'(if0.stall), 64'h0);
    edge1();
    drv0(0, 0, 0, 5, 0, 1, 7, 1); #1;
    check("t3_busy5", 64'(if0.busy), 64'h0020);
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_hold", 64'(if0.stall), 64'h1);
      edge1();
    end
    check("t3_busy_held", 64'(if0.busy), 64'h0020);
    drv0(1, 5, 32'h12345678, 5, 0, 1, 7, 1); #1;
    check("t3_wb_stall", 64'(if0.stall), 64'h0);
    check("t3_wb_rda", 64'(if0.rda), 64'h12345678);
    edge1();
    drv0(0, 0, 0, 0, 0, 1, 6, 1); #1;
    check("t3_busy_after", 64'(if0.busy), 64'h0080);

    // WAW with simultaneous writeback: stall drops and set wins.
    edge1();
    drv0(0, 0, 0, 0, 0, 1, 6, 1); #1;
    check("t4_waw_stall", 64'(if0.stall), 64'h1);
    #2;
    drv0(1, 6, 32'hAAAA0006, 0, 0, 1, 6, 1); #1;
    check("t4_waw_free", 64'(if0.stall), 64'h0);
    edge1();
    check("t4_set_wins", 64'(if0.busy), 64'h00C0);
    drv0(1, 7, 32'h0, 0, 0, 1, 5, 1);
    edge1();
    drv0(1, 2, 32'hFFFF0003, 0, 0, 0, 0, 0);
    edge1();
    drv0(0, 0, 0, 2, 5, 1, 1, 0); #1;
    check("t5_busy_pre", 64'(if0.busy), 64'h0060);
    check("t5_rda_pre", 64'(if0.rda), 64'hFFFF0003);
    check("t5_stall_pre", 64'(if0.stall), 64'h1);

    // Reset between clock edges takes effect at once.
    #1 reset = 1'b1; #1;
    check("t5_busy_rst", 64'(if0.busy), 64'h0);
    check("t5_stall_rst", 64'(if0.stall), 64'h0);
    check("t5_rda_rst", 64'(if0.rda), 64'h0);
    edge1();
    reset = 1'b0;
    drv0(0, 0, 0, 2, 2, 0, 0, 0); #1;
    check("t5_rda_post", 64'(if0.rda), 64'h0);

    // Wide, deep configuration with a writable register 0.
    edge1();
    drv1(1, 0, 64'h0123456789ABCDEF, 0, 0, 0, 0, 0); #1;
    check("t6_bypass0", if1.rda, 64'h0123456789ABCDEF);
    edge1();
    drv1(0, 0, 0, 0, 0, 1, 0, 1); #1;
    check("t6_read0", if1.rda, 64'h0123456789ABCDEF);
    edge1();
    drv1(0, 0, 0, 0, 0, 0, 0, 0); #1;
    check("t6_busy0", 64'(if1.busy), 64'h1);

    // Randomised traffic on both instances with occasional mid-cycle resets.
    for (int c = 0; c < 4000; c++) begin
      edge1();
      reset = 1'b0;
      drv0($urandom_range(0, 9) < 3, raddr(16), $urandom, raddr(16), raddr(16),
           $urandom_range(0, 9) < 7, raddr(16), $urandom_range(0, 9) < 8);
      drv1($urandom_range(0, 9) < 3, raddr(32), {$urandom, $urandom}, raddr(32), raddr(32),
           $urandom_range(0, 9) < 7, raddr(32), $urandom_range(0, 9) < 8);
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
      end
    end
    edge1();
    reset = 1'b0;
    drv0(0, 0, 0, 0, 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0, 0, 0, 0);
    edge1(); edge1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the ASIP ID stage.
- Replaces the fixed 32-bit register file with configurable width and depth, optional hardwired-zero register 0, and write-through bypass.
- Adds a per-register busy scoreboard that the issue logic uses to stall on RAW and WAW hazards against in-flight multi-cycle RSA operations (modmul, modexp).

Parameters:
- WIDTH, 32, data width of each register in bits.
- DEPTH, 16, number of registers; must be a power of two, at least 2.
- ZERO_REG, 1, when 1 register 0 always reads 0, ignores writes and is never busy.
- AW, $clog2(DEPTH), derived address width; not overridden.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  writeback enable.
- rw  in  AW  writeback register address.
- wd  in  WIDTH  writeback data.
- ra  in  AW  read port A address.
- rb  in  AW  read port B address.
- rda  out  WIDTH  read port A data.
- rdb  out  WIDTH  read port B data.
- issue_valid  in  1  the instruction in ID requests issue.
- issue_rd  in  AW  destination of the issuing instruction.
- issue_rd_en  in  1  the issuing instruction writes a destination.
- stall  out  1  issue blocked this cycle.
- busy  out  DEPTH  scoreboard bit vector; bit i set means register i has a pending write.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high. While reset=1, all registers are 0, busy=0, rda=rdb=0 and stall=0.
- Write: on posedge clk, if we=1 then reg[rw] <= wd. If ZERO_REG=1 and rw=0, the write is dropped.
- Read: combinational, zero-cycle latency.
  - rda = wd when we=1 and rw=ra and the write is not dropped; otherwise rda = reg[ra]. This bypass is write-first.
  - If ZERO_REG=1 and ra=0, rda=0 regardless of bypass.
  - rdb follows the same rules on rb.
- Hazard and stall:
  - hazard = issue_valid & (eff_busy[ra] | eff_busy[rb] | (issue_rd_en & eff_busy[issue_rd])).
  - eff_busy = busy & ~(we ? onehot(rw) : 0). A register whose writeback occurs this cycle is treated as free, because the bypass supplies its value.
  - stall = hazard. This is combinational; stall never depends on stall.
- Scoreboard update, on posedge clk:
  - Clear: if we=1, clear busy[rw].
  - Set: if issue_valid & ~stall & issue_rd_en, set busy[issue_rd].
  - Same register set and cleared in one cycle: set wins. The new producer is in flight and the old writeback has completed.
  - Set of register 0 is ignored when ZERO_REG=1.
  - A writeback to a register that is not busy is legal: data is written and busy is unchanged. This covers single-cycle ops that do not use the scoreboard.
- Address range: all addresses are in range by construction, since DEPTH is a power of two.
- Reset mid-operation: asserting reset between clock edges immediately clears all registers and busy, and deasserts stall. The first posedge after reset deasserts behaves normally.

Decomposition:
- Package regfile_pkg holds:
  - default WIDTH and DEPTH;
  - the function onehot(addr, DEPTH);
  - the typedef reg_addr_t.
- One sub-module, regfile_busy_sb, holds:
  - the busy vector;
  - the set/clear and set-wins logic;
  - the eff_busy masking and stall generation.
- The top level holds the storage array, the write logic and the bypass muxes.

Test Plan:
1. Reset, then read ra=0,rb=1 -> rda=0, rdb=0, busy=0, stall=0. Then we=1, rw=1, wd=FFFF0002 -> after the edge rdb=FFFF0002.
2. Bypass: we=1, rw=3, wd=FFFF0004, ra=3, same cycle -> rda=FFFF0004 before the edge. Write rw=0, wd=FFFF000F with ZERO_REG=1 -> ra=0 reads 00000000.
3. Issue issue_rd=5 with issue_rd_en=1 -> busy[5]=1 after the edge. Next issue with ra=5 -> stall=1, held for every cycle until writeback. A cycle with we=1, rw=5, ra=5 -> stall=0 and rda=wd.
4. WAW: busy[6]=1, issue issue_rd=6 -> stall=1. Same cycle we=1, rw=6 -> stall=0, and after the edge busy[6]=1 (set wins).
5. Reset mid-operation: busy=0x0060, reg[2]=FFFF0003. Assert reset between edges -> immediately busy=0, stall=0, reads of reg 2 = 0.
6. Parameter sweep: WIDTH=64, DEPTH=32, ZERO_REG=0. Write rw=0, wd=0123456789ABCDEF -> ra=0 reads 0123456789ABCDEF. Issue rd=0 -> busy[0]=1.
